spio_spinnaker_link_packet_deserializer: RTL

SPIO_SPINNAKER_LINK_PACKET_DESERIALIZER -- requirements
Module: spio_spinnaker_link_packet_deserializer

---
 rtl/spio_spinnaker_link_packet_deserializer_if.sv | 22 ++
 rtl/spio_spinnaker_link_packet_deserializer.sv | 108 ++++++++++
 2 files changed

// File: rtl/spio_spinnaker_link_packet_deserializer_if.sv
// Flit input channel and packet output channel of the SpiNNaker link deserializer.
// The slave modport is the deserializer's view; master is the surrounding logic.
interface spio_spinnaker_link_packet_deserializer_if;
    logic [6:0]  flt_data_2of7;
    logic        flt_vld;
    logic        flt_rdy;
    logic [71:0] pkt_data;
    logic        pkt_vld;
    logic        pkt_rdy;

    // Both channels use valid/ready: a transfer happens on a rising edge where
    // vld && rdy; a source holds vld and its data until that edge.
    modport slave (
        input  flt_data_2of7, flt_vld, pkt_rdy,
        output flt_rdy, pkt_data, pkt_vld
    );

    modport master (
        output flt_data_2of7, flt_vld, pkt_rdy,
        input  flt_rdy, pkt_data, pkt_vld
    );
endinterface

// File: rtl/spio_spinnaker_link_packet_deserializer.sv
// Decodes 2-of-7 RTZ flits into nibbles and assembles 40/72-bit SpiNNaker packets,
// dropping malformed packets with error pulses and a saturating drop counter.
module spio_spinnaker_link_packet_deserializer #(
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      CLK_IN,
    input  logic                      RESETN_IN,
    spio_spinnaker_link_packet_deserializer_if.slave link,
    output logic                      flit_err,
    output logic                      frame_err,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

    logic        is_data;
    logic        is_eop;
    logic [3:0]  nibble;
    logic        accept;
    logic        short_ok;
    logic        long_ok;
    logic [4:0]  count;
    logic [71:0] acc;
    logic        discard;
    logic [71:0] pkt_data_q;
    logic        pkt_vld_q;

    always_comb begin
        is_data = 1'b1;
        is_eop  = 1'b0;
        nibble  = 4'h0;
        case (link.flt_data_2of7)
            7'h11: nibble = 4'h0;
            7'h12: nibble = 4'h1;
            7'h14: nibble = 4'h2;
            7'h18: nibble = 4'h3;
            7'h21: nibble = 4'h4;
            7'h22: nibble = 4'h5;
            7'h24: nibble = 4'h6;
            7'h28: nibble = 4'h7;
            7'h41: nibble = 4'h8;
            7'h42: nibble = 4'h9;
            7'h44: nibble = 4'hA;
            7'h48: nibble = 4'hB;
            7'h03: nibble = 4'hC;
            7'h06: nibble = 4'hD;
            7'h0C: nibble = 4'hE;
            7'h09: nibble = 4'hF;
            7'h60: begin
                is_data = 1'b0;
                is_eop  = 1'b1;
            end
            default: is_data = 1'b0;
        endcase
    end

    // Only an EOP can be held back: it would overwrite a packet not yet taken.
    assign link.flt_rdy = ~(link.flt_vld & is_eop & pkt_vld_q & ~link.pkt_rdy);
    assign accept       = link.flt_vld & link.flt_rdy;

    // Header bit 1 selects payload-present (long) packets.
    assign short_ok = (count == 5'd10) && !acc[1];
    assign long_ok  = (count == 5'd18) &&  acc[1];

    always_ff @(posedge CLK_IN) begin
        if (!RESETN_IN) begin
            flit_err   <= 1'b0;
            frame_err  <= 1'b0;
            drop_cnt   <= '0;
            count      <= 5'd0;
            acc        <= '0;
            discard    <= 1'b0;
            pkt_data_q <= '0;
            pkt_vld_q  <= 1'b0;
        end else begin
            flit_err  <= 1'b0;
            frame_err <= 1'b0;
            if (pkt_vld_q && link.pkt_rdy) pkt_vld_q <= 1'b0;
            if (accept) begin
                if (is_data) begin
                    // Nibbles beyond the 18th are counted (overlong) but not stored.
                    for (int i = 0; i < 18; i++) begin
                        if (count == 5'(i)) acc[4*i +: 4] <= nibble;
                    end
                    if (count != 5'd19) count <= count + 5'd1;
                end else if (is_eop) begin
                    if (count != 5'd0 || discard) begin
                        if (!discard && (short_ok || long_ok)) begin
                            pkt_vld_q  <= 1'b1;
                            pkt_data_q <= short_ok ? {32'd0, acc[39:0]} : acc;
                        end else begin
                            frame_err <= 1'b1;
                            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
                        end
                    end
                    count   <= 5'd0;
                    acc     <= '0;
                    discard <= 1'b0;
                end else begin
                    flit_err <= 1'b1;
                    discard  <= 1'b1;
                end
            end
        end
    end

    assign link.pkt_data = pkt_data_q;
    assign link.pkt_vld  = pkt_vld_q;

endmodule
